// File: rtl/mux_cfg_pkg.sv
// Shared types and helpers for the mux configuration loader.
// Holds the loader state encoding and the bitstream word-count helper.
package mux_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_COMMIT,
    S_DONE,
    S_ERR
  } state_e;

  function automatic int word_count(input int num_mem,
                                    input int data_w);
    return (num_mem + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/mux_config_loader_if.sv
// Bitstream valid/ready channel feeding the mux configuration loader.
// The source drives valid/data, the loader drives ready.
interface mux_config_loader_if #(
  parameter int DATA_W = 8
) ();

  logic              bs_valid;
  logic [DATA_W-1:0] bs_data;
  logic              bs_ready;

  modport master (
    output bs_valid,
    output bs_data,
    input  bs_ready
  );

  modport slave (
    input  bs_valid,
    input  bs_data,
    output bs_ready
  );

endinterface

// File: rtl/mux_cfg_shadow_reg.sv
// Shadow register for incoming config bits plus the mem/mem_inv outputs.
// Shadow is written a word-slice at a time; outputs move only on commit.
module mux_cfg_shadow_reg #(
  parameter int NUM_MEM = 20,
  parameter int DATA_W  = 8,
  parameter int CW      = $clog2(NUM_MEM + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               ld_en_i,
  input  logic [CW-1:0]      ld_base_i,
  input  logic [DATA_W-1:0]  ld_data_i,
  input  logic               commit_i,
  output logic [0:NUM_MEM-1] mem_o,
  output logic [0:NUM_MEM-1] mem_inv_o
);

  logic [0:NUM_MEM-1] sh_q, sh_d;
  logic [0:NUM_MEM-1] mem_q, inv_q;
  logic [NUM_MEM-1:0] dsh, msk;

  // Word bit i lands on shadow element ld_base+i; bits past the end drop off.
  always_comb begin
    dsh  = NUM_MEM'(ld_data_i) << ld_base_i;
    msk  = NUM_MEM'({DATA_W{1'b1}}) << ld_base_i;
    sh_d = sh_q;
    if (clr_i) begin
      sh_d = '0;
    end else if (ld_en_i) begin
      for (int j = 0; j < NUM_MEM; j++) begin
        if (msk[j]) sh_d[j] = dsh[j];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      mem_q <= '0;
      inv_q <= '1;
    end else begin
      sh_q <= sh_d;
      if (commit_i) begin
        mem_q <= sh_q;
        inv_q <= ~sh_q;
      end
    end
  end

  assign mem_o     = mem_q;
  assign mem_inv_o = inv_q;

endmodule

// File: rtl/mux_config_loader.sv
// Loads NUM_MEM mux select bits from a word stream, checks an XOR
// checksum and commits them atomically to the mem/mem_inv outputs.
module mux_config_loader
  import mux_cfg_pkg::*;
#(
  parameter int NUM_MEM = 20,
  parameter int DATA_W  = 8
) (
  input  logic               prog_clk,
  input  logic               pReset_n,
  input  logic               start,
  input  logic               abort,
  mux_config_loader_if.slave bs,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [0:NUM_MEM-1] mem,
  output logic [0:NUM_MEM-1] mem_inv
);

  localparam int CW = $clog2(NUM_MEM + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              ready, xfer, last, pad_bad;
  logic              clr, ld_en, commit;
  logic [CW-1:0]     rem, k;
  logic [DATA_W-1:0] keep;

  assign ready       = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign bs.bs_ready = ready;
  assign xfer        = bs.bs_valid && ready;

  // Final data word carries only rem live bits; the rest must be zero.
  always_comb begin
    rem     = CW'(NUM_MEM) - cnt_q;
    last    = int'(rem) <= DATA_W;
    k       = last ? rem : CW'(DATA_W);
    keep    = {DATA_W{1'b1}} >> (DATA_W - int'(rem));
    pad_bad = last && (|(bs.bs_data & ~keep));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    done_d  = done_q;
    err_d   = err_q;
    clr     = 1'b0;
    ld_en   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start && !abort) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          csum_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          clr     = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
          clr     = 1'b1;
        end else if (xfer) begin
          ld_en  = 1'b1;
          cnt_d  = cnt_q + k;
          csum_d = csum_q ^ bs.bs_data;
          if (last) begin
            if (pad_bad) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
          clr     = 1'b1;
        end else if (xfer) begin
          if (bs.bs_data == csum_q) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_COMMIT: begin
        commit  = 1'b1;
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy = ready || (state_q == S_COMMIT);
  assign done = done_q;
  assign err  = err_q;

  mux_cfg_shadow_reg #(
    .NUM_MEM (NUM_MEM),
    .DATA_W  (DATA_W),
    .CW      (CW)
  ) u_shadow (
    .clk_i     (prog_clk),
    .rst_ni    (pReset_n),
    .clr_i     (clr),
    .ld_en_i   (ld_en),
    .ld_base_i (cnt_q),
    .ld_data_i (bs.bs_data),
    .commit_i  (commit),
    .mem_o     (mem),
    .mem_inv_o (mem_inv)
  );

endmodule
